// File: rtl/render_pkg.sv
// Shared types and constants for the render arbiter slice.
// Optional pixel clipping is enabled by defining RENDER_CLIP_EN.
package render_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_STREAM  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    localparam int SCREEN_X_DEF = 640;
    localparam int SCREEN_Y_DEF = 480;

    function automatic int coord_w(input int res);
        return $clog2(res) + 1;
    endfunction

    localparam int X_W = coord_w(SCREEN_X_DEF);
    localparam int Y_W = coord_w(SCREEN_Y_DEF);

endpackage

// File: rtl/render_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/render_arbiter.sv
// Grants renderers the VGA plot port in round-robin order and forwards pixels.
// Define RENDER_CLIP_EN to suppress off-screen pixels.
module render_arbiter
    import render_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int SCREEN_X = SCREEN_X_DEF,
    parameter int SCREEN_Y = SCREEN_Y_DEF,
    parameter int TIMEOUT  = 'd320000,
    localparam int XW = coord_w(SCREEN_X),
    localparam int YW = coord_w(SCREEN_Y),
    localparam int PW = $clog2(NUM_SRC),
    localparam int CW = $clog2(TIMEOUT) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [NUM_SRC*XW-1:0] src_x,
    input  logic [NUM_SRC*YW-1:0] src_y,
    input  logic [NUM_SRC*3-1:0]  src_col,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC-1:0]    src_done,
    output logic [NUM_SRC-1:0]    src_start,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [XW-1:0]         vga_x,
    output logic [YW-1:0]         vga_y,
    output logic [2:0]            vga_colour,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  timeout_err
);

    state_t               state;
    state_t               state_nx;
    logic [PW-1:0]        sel;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        pick_idx;
    logic [NUM_SRC-1:0]   pick_oh;
    logic [NUM_SRC-1:0]   sel_oh;
    logic                 pick_any;
    logic [CW-1:0]        cnt;
    logic                 done_hit;
    logic                 to_hit;
    logic                 pix_hit;
    logic                 in_range;
    logic [XW-1:0]        px;
    logic [YW-1:0]        py;
    logic [2:0]           pc;

    rr_pick #(.N(NUM_SRC), .PW(PW)) u_pick (
        .req (src_req),
        .ptr (ptr),
        .sel (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign px = src_x[sel*XW +: XW];
    assign py = src_y[sel*YW +: YW];
    assign pc = src_col[sel*3 +: 3];

`ifdef RENDER_CLIP_EN
    assign in_range = (px < XW'(SCREEN_X)) && (py < YW'(SCREEN_Y));
`else
    assign in_range = 1'b1;
`endif

    assign done_hit = (state == S_STREAM) && src_done[sel];
    assign to_hit   = (state == S_STREAM) && (cnt == CW'(TIMEOUT - 1));
    assign pix_hit  = (state == S_STREAM) && src_valid[sel];

    always_comb begin
        state_nx  = state;
        src_start = '0;
        src_grant = '0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (pick_any) state_nx = S_GRANT;
            end
            S_GRANT: begin
                src_start = sel_oh;
                src_grant = sel_oh;
                state_nx  = S_STREAM;
            end
            S_STREAM: begin
                src_grant = sel_oh;
                if (done_hit || to_hit) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel         <= '0;
            sel_oh      <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE && pick_any) begin
                sel    <= pick_idx;
                sel_oh <= pick_oh;
            end
            if (state == S_GRANT) cnt <= '0;
            else if (state == S_STREAM && cnt != '1) cnt <= cnt + CW'(1);
            if (to_hit && !done_hit) timeout_err <= 1'b1;
            if (state == S_RELEASE) begin
                ptr <= (sel == PW'(NUM_SRC - 1)) ? '0 : sel + PW'(1);
            end
        end
    end

    // Coordinates hold their last value whenever nothing is plotted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= COL_BLACK;
            vga_plot   <= 1'b0;
        end else if (pix_hit && in_range) begin
            vga_x      <= px;
            vga_y      <= py;
            vga_colour <= pc;
            vga_plot   <= 1'b1;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule
